// File: rtl/can_bit_destuffer.sv
// Receive-side CAN bit de-stuffer: flags the bit that follows STUFF_LEN identical bits.
// Optional stuff_error output is enabled by defining CAN_DESTUFF_STUFF_ERR_EN.
module can_bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic sample_point,
  output logic bit_out,
  output logic remove_flag
`ifdef CAN_DESTUFF_STUFF_ERR_EN
  ,
  output logic stuff_error
`endif
);

  localparam logic [CNT_W-1:0] STUFF_SLOT = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             prev_bit, prev_bit_d;
  logic [CNT_W-1:0] run_cnt, run_cnt_d;
  logic             bit_out_d, remove_flag_d;
`ifdef CAN_DESTUFF_STUFF_ERR_EN
  logic             stuff_error_d;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    prev_bit_d    = prev_bit;
    run_cnt_d     = run_cnt;
    bit_out_d     = bit_out;
    remove_flag_d = remove_flag;
`ifdef CAN_DESTUFF_STUFF_ERR_EN
    stuff_error_d = stuff_error;
`endif

    if (sample_point) begin
      bit_out_d = bit_in;
`ifdef CAN_DESTUFF_STUFF_ERR_EN
      stuff_error_d = 1'b0;
`endif
      if (run_cnt == STUFF_SLOT) begin
        remove_flag_d = 1'b1;
        if (bit_in != prev_bit) begin
          // A valid stuff bit is itself the first bit of the next run.
          run_cnt_d  = CNT_ONE;
          prev_bit_d = bit_in;
        end else begin
          // Violation: stay parked in the slot so further identical bits are flagged too.
`ifdef CAN_DESTUFF_STUFF_ERR_EN
          stuff_error_d = 1'b1;
`endif
        end
      end else if (run_cnt == '0 || bit_in != prev_bit) begin
        remove_flag_d = 1'b0;
        run_cnt_d     = CNT_ONE;
        prev_bit_d    = bit_in;
      end else begin
        remove_flag_d = 1'b0;
        run_cnt_d     = run_cnt + CNT_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_bit    <= 1'b1;
      run_cnt     <= '0;
      bit_out     <= 1'b1;
      remove_flag <= 1'b0;
    end else begin
      prev_bit    <= prev_bit_d;
      run_cnt     <= run_cnt_d;
      bit_out     <= bit_out_d;
      remove_flag <= remove_flag_d;
    end
  end

`ifdef CAN_DESTUFF_STUFF_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stuff_error <= 1'b0;
    else     stuff_error <= stuff_error_d;
  end
`endif

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Self-checking bench for can_bit_destuffer; expected outputs are queued per strobe and popped after the edge.
`timescale 1ns/1ps
module tb_can_bit_destuffer;

  logic clk = 1'b0;
  logic rst;
  logic bit_in;
  logic sample_point;
  logic bit_out;
  logic remove_flag;
`ifdef CAN_DESTUFF_STUFF_ERR_EN
  logic stuff_error;
`endif

  typedef struct packed {
    logic bo;
    logic rf;
    logic se;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  can_bit_destuffer #(.STUFF_LEN(5), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .sample_point (sample_point),
    .bit_out      (bit_out),
    .remove_flag  (remove_flag)
`ifdef CAN_DESTUFF_STUFF_ERR_EN
    ,
    .stuff_error  (stuff_error)
`endif
  );

  task automatic check(input string tag, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".bit_out"}, bit_out, e.bo);
    check({tag, ".remove_flag"}, remove_flag, e.rf);
`ifdef CAN_DESTUFF_STUFF_ERR_EN
    check({tag, ".stuff_error"}, stuff_error, e.se);
`endif
  endtask

  // One strobe: queue the expectation, drive, then compare just after the capturing edge; one idle clk follows.
  task automatic strobe(input string tag, input logic b, input logic rf, input logic se);
    exp_t e;
    sb.push_back('{bo: b, rf: rf, se: se});
    @(negedge clk);
    bit_in       = b;
    sample_point = 1'b1;
    @(posedge clk);
    #1;
    sample_point = 1'b0;
    if (sb.size() == 0) begin
      check({tag, ".queue_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e);
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs(tag, '{bo: 1'b1, rf: 1'b0, se: 1'b0});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t hold;
    rst          = 1'b1;
    bit_in       = 1'b0;
    sample_point = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("por", '{bo: 1'b1, rf: 1'b0, se: 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // 1: six recessive bits, the sixth violates the stuff slot.
    for (int i = 1; i <= 5; i++) strobe($sformatf("t1.s%0d", i), 1'b1, 1'b0, 1'b0);
    strobe("t1.s6", 1'b1, 1'b1, 1'b1);

    // 2: differing bit after a violation is taken as the stuff bit.
    strobe("t2.s1", 1'b0, 1'b1, 1'b0);
    strobe("t2.s2", 1'b1, 1'b0, 1'b0);
    strobe("t2.s3", 1'b0, 1'b0, 1'b0);
    strobe("t2.s4", 1'b1, 1'b0, 1'b0);
    strobe("t2.s5", 1'b0, 1'b0, 1'b0);

    // 3: the last 0 of test 2 counts, so the slot falls on the 5th 0 here.
    for (int i = 1; i <= 4; i++) strobe($sformatf("t3.s%0d", i), 1'b0, 1'b0, 1'b0);
    strobe("t3.s5", 1'b0, 1'b1, 1'b1);
    strobe("t3.s6", 1'b0, 1'b1, 1'b1);

    // 5: outputs hold with no strobe while bit_in toggles.
    hold = '{bo: 1'b0, rf: 1'b1, se: 1'b1};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bit_in = ~bit_in;
      @(posedge clk);
      #1;
      check_outputs($sformatf("t5.idle%0d", i), hold);
    end

    // 4: valid stuff 0 after five 1s starts a new run of zeros.
    do_reset("t4.rst");
    for (int i = 1; i <= 5; i++) strobe($sformatf("t4.s%0d", i), 1'b1, 1'b0, 1'b0);
    strobe("t4.s6", 1'b0, 1'b1, 1'b0);
    for (int i = 7; i <= 9; i++) strobe($sformatf("t4.s%0d", i), 1'b0, 1'b0, 1'b0);
    strobe("t4.s10", 1'b1, 1'b0, 1'b0);

    // 6: asynchronous reset between edges after four identical bits.
    for (int i = 1; i <= 4; i++) strobe($sformatf("t6.pre%0d", i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("t6.async_rst", '{bo: 1'b1, rf: 1'b0, se: 1'b0});
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) strobe($sformatf("t6.s%0d", i), 1'b0, 1'b0, 1'b0);
    strobe("t6.s6", 1'b0, 1'b1, 1'b1);

    check("sb.drained", sb.size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
